idli_sqi_resp_m: RTL and testbench
==================================

IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning log2 of the memory depth in bytes (legal range 4..16).
REQ-002 The block SHALL have port i_sqi_gck, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port i_sqi_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port i_sqi_sck, input, 1 bit: serial clock from the initiator, sampled on i_sqi_gck.
REQ-005 The block SHALL have port i_sqi_cs, input, 1 bit: chip select, active-low.
REQ-006 The block SHALL have port i_sqi_sio, input, 4 bits: nibble from the initiator.
REQ-007 The block SHALL have port o_sqi_sio, output, 4 bits: nibble driven to the initiator.
REQ-008 The block SHALL have port o_sqi_sio_oe, output, 1 bit: high when o_sqi_sio is driven.

Function
REQ-009 The block SHALL register i_sqi_sck each gck; rise = prev 0, now 1; fall = prev 1, now 0; each sck phase is held for at least 1 gck.
REQ-010 The block SHALL sample i_sqi_sio only on a detected rise while i_sqi_cs is low.
REQ-011 The block SHALL implement states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE.
REQ-012 In IDLE, i_sqi_cs low SHALL move the block to CMD with the nibble counter cleared.
REQ-013 CMD SHALL collect 2 nibbles, high nibble first; 0x03 = read, 0x02 = write, and any other value SHALL go to IGNORE.
REQ-014 ADDR SHALL collect 4 nibbles (16-bit address, MS nibble first); only the low ADDR_W bits SHALL be used.
REQ-015 After ADDR, a read SHALL enter DUMMY for exactly 2 rises, and a write SHALL enter WDATA.
REQ-016 WDATA SHALL assemble bytes high nibble first, commit each byte on its second rise, then increment the address.
REQ-017 On the fall following the last DUMMY rise, RDATA SHALL drive the high nibble of mem[addr] and assert o_sqi_sio_oe.
REQ-018 Each subsequent fall SHALL drive the next nibble (low, then the high nibble of addr+1, and so on).
REQ-019 The read address SHALL increment after the low nibble is driven.
REQ-020 Address increment SHALL wrap modulo 2^ADDR_W: the address after 2^ADDR_W-1 is 0.
REQ-021 o_sqi_sio_oe SHALL be low in every state except RDATA.
REQ-022 IGNORE SHALL discard all sck activity until cs goes high.
REQ-023 i_sqi_cs high in any state SHALL force IDLE and drop oe on the next gck, and any half-written byte SHALL be discarded.
REQ-024 If a cs rise and an sck rise occur in the same gck, the cs rise SHALL take priority and the nibble SHALL be discarded.
REQ-025 Memory SHALL be a 2^ADDR_W x 8 register array, with one byte write per commit and no read-during-write hazard within a transaction.

Reset
REQ-026 While i_sqi_rst_n is low, the block SHALL hold the state at IDLE, counters and address at 0, o_sqi_sio at 0, o_sqi_sio_oe at 0, and the sck history at 0.
REQ-027 Memory contents SHALL NOT be reset and are undefined until written.
REQ-028 When reset asserts mid-transaction, the block SHALL abort the transaction, leave committed bytes intact, and discard the partial byte.

Configuration
REQ-029 When IDLI_SQI_RESP_BKDOOR_EN is defined, the block SHALL add inputs i_bd_wr (1), i_bd_addr (ADDR_W) and i_bd_data (8).
REQ-030 With IDLI_SQI_RESP_BKDOOR_EN defined, i_bd_wr high SHALL write i_bd_data to mem[i_bd_addr] on that gck.
REQ-031 With IDLI_SQI_RESP_BKDOOR_EN defined, a backdoor write SHALL take priority over a same-cycle serial commit to the same address.
REQ-032 When IDLI_SQI_RESP_BKDOOR_EN is undefined, these ports and the associated logic SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-033 The bench SHALL cover: write cmd 0x02, addr 0x0010, data 0xA5 0x3C, cs high -> mem[0x10]=0xA5, mem[0x11]=0x3C, and oe low throughout.
REQ-034 The bench SHALL cover: read cmd 0x03, addr 0x0010, 2 dummy rises, then 4 data falls -> o_sqi_sio = 0xA, 0x5, 0x3, 0xC with oe high from the first data fall.
REQ-035 The bench SHALL cover: with ADDR_W=8, a write starting at addr 0x00FF with data 0x11 0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22 (wrap).
REQ-036 The bench SHALL cover: cmd 0x9F followed by 8 nibbles -> IGNORE state, oe low, memory unchanged, and the next transaction after cs high behaves normally.
REQ-037 The bench SHALL cover: a write of 0x77 to 0x20 aborted by cs high after 1 data nibble -> mem[0x20] unchanged, and the following read of 0x20 returns the old value.
REQ-038 The bench SHALL cover: reset asserted during RDATA -> oe=0 and o_sqi_sio=0 immediately (asynchronous), state IDLE, and previously written data still readable.

Source files
------------

// File: rtl/idli_sqi_resp_m.sv
// idli_sqi_resp_m: quad-serial responder backed by a 2^ADDR_W x 8 register memory.
// Define IDLI_SQI_RESP_BKDOOR_EN to add a direct backdoor write port.
//
// state  | meaning
// IDLE   | deselected, waiting for cs low
// CMD    | collecting the 2 command nibbles
// ADDR   | collecting the 4 address nibbles
// DUMMY  | 2 turnaround rises ahead of read data
// RDATA  | driving read nibbles on sck falls
// WDATA  | assembling and committing write bytes
// IGNORE | unknown command, waiting for cs high
module idli_sqi_resp_m #(
  parameter int ADDR_W = 8
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_sck,
  input  logic              i_sqi_cs,
  input  logic [3:0]        i_sqi_sio,
`ifdef IDLI_SQI_RESP_BKDOOR_EN
  input  logic              i_bd_wr,
  input  logic [ADDR_W-1:0] i_bd_addr,
  input  logic [7:0]        i_bd_data,
`endif
  output logic [3:0]        o_sqi_sio,
  output logic              o_sqi_sio_oe
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  state_t            state_q, state_d;
  logic              sck_q;
  logic              sck_rise, sck_fall, nib_rise;
  logic [1:0]        cnt_q;
  logic [3:0]        nib_hi_q;
  logic              is_read_q;
  logic [ADDR_W-1:0] addr_q;
  logic              nib_lo_q;
  logic [3:0]        sio_q;
  logic              oe_q;
  logic [7:0]        nib_pair;
  logic [7:0]        rd_byte;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  logic cnt_inc, cnt_wrap, hi_load, cmd_load, addr_shift, mem_we, rd_drive;

  assign sck_rise = ~sck_q & i_sqi_sck;
  assign sck_fall = sck_q & ~i_sqi_sck;
  // cs high wins over a coincident sck rise: the nibble is dropped
  assign nib_rise = sck_rise & ~i_sqi_cs;
  assign nib_pair = {nib_hi_q, i_sqi_sio};
  assign rd_byte  = mem[addr_q];

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_sqi_cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = CMD;
        CMD:   if (nib_rise && cnt_q == 2'd1)
                 state_d = (nib_pair == CMD_READ || nib_pair == CMD_WRITE) ? ADDR : IGNORE;
        ADDR:  if (nib_rise && cnt_q == 2'd3)
                 state_d = is_read_q ? DUMMY : WDATA;
        DUMMY: if (nib_rise && cnt_q == 2'd1)
                 state_d = RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_inc    = 1'b0;
    cnt_wrap   = 1'b0;
    hi_load    = 1'b0;
    cmd_load   = 1'b0;
    addr_shift = 1'b0;
    mem_we     = 1'b0;
    rd_drive   = 1'b0;
    case (state_q)
      CMD: begin
        cnt_inc  = nib_rise;
        hi_load  = nib_rise;
        cmd_load = nib_rise && cnt_q == 2'd1;
        cnt_wrap = cmd_load;
      end
      ADDR: begin
        cnt_inc    = nib_rise;
        addr_shift = nib_rise;
        cnt_wrap   = nib_rise && cnt_q == 2'd3;
      end
      DUMMY: begin
        cnt_inc  = nib_rise;
        cnt_wrap = nib_rise && cnt_q == 2'd1;
      end
      WDATA: begin
        cnt_inc  = nib_rise;
        hi_load  = nib_rise && cnt_q == 2'd0;
        mem_we   = nib_rise && cnt_q == 2'd1;
        cnt_wrap = mem_we;
      end
      RDATA: rd_drive = sck_fall & ~i_sqi_cs;
      default: ;
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      sck_q     <= 1'b0;
      cnt_q     <= 2'd0;
      nib_hi_q  <= 4'd0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      nib_lo_q  <= 1'b0;
    end else begin
      sck_q <= i_sqi_sck;
      if (i_sqi_cs || state_q == IDLE || cnt_wrap) cnt_q <= 2'd0;
      else if (cnt_inc)                            cnt_q <= cnt_q + 2'd1;
      if (hi_load)  nib_hi_q  <= i_sqi_sio;
      if (cmd_load) is_read_q <= (nib_pair == CMD_READ);
      // four shifts push the full 16-bit address through; only the low ADDR_W bits remain
      if (addr_shift)
        addr_q <= ADDR_W'({addr_q, i_sqi_sio});
      else if (mem_we || (rd_drive && nib_lo_q))
        addr_q <= addr_q + ADDR_W'(1);
      if (i_sqi_cs || state_q != RDATA) nib_lo_q <= 1'b0;
      else if (rd_drive)                nib_lo_q <= ~nib_lo_q;
    end
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      sio_q <= 4'd0;
      oe_q  <= 1'b0;
    end else if (i_sqi_cs || state_q != RDATA) begin
      sio_q <= 4'd0;
      oe_q  <= 1'b0;
    end else if (rd_drive) begin
      sio_q <= nib_lo_q ? rd_byte[3:0] : rd_byte[7:4];
      oe_q  <= 1'b1;
    end
  end

  assign o_sqi_sio    = sio_q;
  assign o_sqi_sio_oe = oe_q;

  // storage is deliberately unreset; backdoor is last so it wins an address clash
  always_ff @(posedge i_sqi_gck) begin
    if (mem_we) mem[addr_q] <= nib_pair;
`ifdef IDLI_SQI_RESP_BKDOOR_EN
    if (i_bd_wr) mem[i_bd_addr] <= i_bd_data;
`endif
  end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// tb_idli_sqi_resp_m: scoreboard bench for idli_sqi_resp_m, reads checked against a byte model.
`timescale 1ns/1ps
module tb_idli_sqi_resp_m;

  localparam int ADDR_W = 8;

  logic       gck = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic [3:0] sio_in = 4'd0;
  logic [3:0] sio_out;
  logic       oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [0:255];
  logic [3:0] exp_q [$];

  always #5 gck = ~gck;

  idli_sqi_resp_m #(.ADDR_W(ADDR_W)) dut (
    .i_sqi_gck    (gck),
    .i_sqi_rst_n  (rst_n),
    .i_sqi_sck    (sck),
    .i_sqi_cs     (cs),
    .i_sqi_sio    (sio_in),
    .o_sqi_sio    (sio_out),
    .o_sqi_sio_oe (oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n);
    sio_in = n;
    sck = 1'b1;
    repeat (2) @(negedge gck);
    sck = 1'b0;
    repeat (2) @(negedge gck);
  endtask

  task automatic cs_on();
    @(negedge gck);
    cs = 1'b0;
    repeat (2) @(negedge gck);
  endtask

  task automatic cs_off();
    cs = 1'b1;
    sio_in = 4'd0;
    repeat (3) @(negedge gck);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a);
    send_nib(cmd[7:4]);
    send_nib(cmd[3:0]);
    for (int i = 3; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic pop_cmp(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_oe"}, 32'(oe), 32'd1);
      chk(tag, 32'(sio_out), 32'(e));
    end
  endtask

  task automatic write2(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] idx;
    cs_on();
    send_hdr(8'h02, a);
    send_nib(d0[7:4]); chk("wr_oe", 32'(oe), 32'd0);
    send_nib(d0[3:0]); chk("wr_oe", 32'(oe), 32'd0);
    send_nib(d1[7:4]); chk("wr_oe", 32'(oe), 32'd0);
    send_nib(d1[3:0]); chk("wr_oe", 32'(oe), 32'd0);
    cs_off();
    idx = a[7:0];
    model[idx] = d0;
    idx = idx + 8'd1;
    model[idx] = d1;
  endtask

  task automatic read_chk(input logic [15:0] a, input int n, input string tag);
    logic [7:0] idx;
    logic [7:0] b;
    idx = a[7:0];
    for (int k = 0; k < n; k++) begin
      b = model[idx];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
      idx = idx + 8'd1;
    end
    cs_on();
    send_hdr(8'h03, a);
    chk({tag, "_hdr_oe"}, 32'(oe), 32'd0);
    send_nib(4'd0);
    chk({tag, "_dummy_oe"}, 32'(oe), 32'd0);
    send_nib(4'd0);
    for (int k = 0; k < 2 * n; k++) begin
      if (k > 0) send_nib(4'd0);
      pop_cmp(tag);
    end
    cs_off();
    chk({tag, "_oe_drop"}, 32'(oe), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge gck);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_sio", 32'(sio_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);

    // basic write then read back
    write2(16'h0010, 8'hA5, 8'h3C);
    read_chk(16'h0010, 2, "rd10");

    // address wrap on write and on read
    write2(16'h00FF, 8'h11, 8'h22);
    read_chk(16'h00FF, 2, "rdwrap");

    // unknown command: everything until cs high is ignored
    cs_on();
    send_nib(4'h9);
    send_nib(4'hF);
    begin
      logic [3:0] junk [8];
      junk = '{4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
      for (int i = 0; i < 8; i++) begin
        send_nib(junk[i]);
        chk("ign_oe", 32'(oe), 32'd0);
      end
    end
    cs_off();
    read_chk(16'h0010, 2, "rd_after_ign");

    // aborted write after one data nibble leaves old contents
    write2(16'h0020, 8'h5A, 8'hC3);
    cs_on();
    send_hdr(8'h02, 16'h0020);
    send_nib(4'h7);
    cs_off();
    read_chk(16'h0020, 1, "rd_abort");

    // cs rise coincident with the committing sck rise drops the byte
    write2(16'h0030, 8'h12, 8'h34);
    cs_on();
    send_hdr(8'h02, 16'h0030);
    send_nib(4'h9);
    sio_in = 4'h9;
    sck = 1'b1;
    cs = 1'b1;
    repeat (2) @(negedge gck);
    sck = 1'b0;
    repeat (3) @(negedge gck);
    read_chk(16'h0030, 1, "rd_csprio");

    // asynchronous reset in the middle of a read
    exp_q.push_back(model[8'h10][7:4]);
    cs_on();
    send_hdr(8'h03, 16'h0010);
    send_nib(4'd0);
    send_nib(4'd0);
    pop_cmp("rd_pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_sio", 32'(sio_out), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'd0);
    @(negedge gck);
    cs = 1'b1;
    sck = 1'b0;
    @(negedge gck);
    rst_n = 1'b1;
    repeat (2) @(negedge gck);
    exp_q.delete();
    read_chk(16'h0010, 2, "rd_after_rst");
    read_chk(16'h00FF, 2, "rd_after_rst_wrap");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
